// File: rtl/bus_interface_unit.sv
// Runs one asynchronous 68000-style bus cycle per core request: strobes, DTACK/BERR wait, completion status.
// Optional BIU_TIMEOUT_EN: ends a WAIT after TIMEOUT_CYCLES without DTACK/BERR as a bus error.
module bus_interface_unit #(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_be,
    input  logic [15:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] A,
    output logic              AS,
    output logic              UDS,
    output logic              LDS,
    output logic              RW,
    output logic [15:0]       D_OUT,
    output logic              D_OE,
    input  logic [15:0]       D_IN,
    input  logic              DTACK,
    input  logic              BERR
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_STRB = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    logic [2:0]  state;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic        dtack_meta, dtack_s, berr_meta, berr_s;
`ifdef BIU_TIMEOUT_EN
    logic [15:0] cnt;
`endif

    assign busy = (state != S_IDLE);

    // Strobes and D_OE are registers, so the async reset negates them immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            rw_q       <= 1'b1;
            be_q       <= '0;
            wdata_q    <= '0;
            dtack_meta <= 1'b0;
            dtack_s    <= 1'b0;
            berr_meta  <= 1'b0;
            berr_s     <= 1'b0;
            A          <= '0;
            AS         <= 1'b1;
            UDS        <= 1'b1;
            LDS        <= 1'b1;
            RW         <= 1'b1;
            D_OUT      <= '0;
            D_OE       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
`ifdef BIU_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            dtack_meta <= DTACK;
            dtack_s    <= dtack_meta;
            berr_meta  <= BERR;
            berr_s     <= berr_meta;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (req_be != 2'b00) begin
                            A       <= req_addr;
                            RW      <= req_rw;
                            rw_q    <= req_rw;
                            be_q    <= req_be;
                            wdata_q <= req_wdata;
                            state   <= S_ADDR;
                        end else begin
                            // Empty byte mask: complete without touching the bus.
                            err   <= 1'b0;
                            done  <= 1'b1;
                            state <= S_END;
                        end
                    end
                end
                S_ADDR: begin
                    AS <= 1'b0;
                    if (rw_q) begin
                        UDS <= ~be_q[1];
                        LDS <= ~be_q[0];
                    end else begin
                        D_OUT <= wdata_q;
                        D_OE  <= 1'b1;
                    end
                    state <= S_STRB;
                end
                S_STRB: begin
                    // Write data strobes trail AS by one cycle so D is settled.
                    if (!rw_q) begin
                        UDS <= ~be_q[1];
                        LDS <= ~be_q[0];
                    end
`ifdef BIU_TIMEOUT_EN
                    cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (berr_s) begin
                        {AS, UDS, LDS} <= 3'b111;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_END;
                    end else if (dtack_s) begin
                        {AS, UDS, LDS} <= 3'b111;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        if (rw_q) rdata <= D_IN;
                        state <= S_END;
                    end
`ifdef BIU_TIMEOUT_EN
                    else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        {AS, UDS, LDS} <= 3'b111;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_END;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                S_END: begin
                    done  <= 1'b0;
                    D_OE  <= 1'b0;
                    RW    <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bus_interface_unit.md
Name: bus_interface_unit

Overview:
- Runs one asynchronous 68000-style bus cycle (A, AS, UDS, LDS, RW, D, DTACK, BERR) per request from the V68k core.
- Sits directly downstream of the core's FETCH/WAIT_FOR_INSTRUCTION sequencing. The core issues a single-word read or write request; this block drives the strobes, waits for DTACK or BERR, and returns read data and completion status.
- Moves the handshake timing out of the core's state machine.

Parameters:
- ADDR_W, 23: word address width (A[23:1]).
- TIMEOUT_CYCLES, 64: WAIT cycles before a forced bus error. Used only with BIU_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- req  input  1  core request; sampled only in IDLE.
- req_rw  input  1  1 = read, 0 = write.
- req_addr  input  23  word address.
- req_be  input  2  byte enables; [1] = upper byte (UDS), [0] = lower byte (LDS).
- req_wdata  input  16  write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = bus error (or timeout).
- rdata  output  16  read data; valid from done until the next read completes.
- A  output  23  address bus.
- AS, UDS, LDS  output  1 each  active-low strobes.
- RW  output  1  1 = read, 0 = write.
- D_OUT  output  16  write data to the bus.
- D_OE  output  1  high while this block drives D.
- D_IN  input  16  data bus input.
- DTACK  input  1  active-high, asynchronous.
- BERR  input  1  active-high, asynchronous.

Behaviour:
- Reset (asynchronous, RESET=0): state IDLE, AS=UDS=LDS=1, RW=1, D_OE=0, A=0, D_OUT=0, busy=0, done=0, err=0, rdata=0, synchronizers cleared.
- Reset mid-cycle: strobes negate and D_OE drops immediately, without waiting for a clock edge. No done pulse is produced.
- DTACK and BERR each pass through a 2-flop synchronizer: dtack_s and berr_s. D_IN is sampled unsynchronized, on the same edge that acts on dtack_s.
- IDLE:
  - req=1 and req_be!=0: latch addr, rw, be and wdata. Drive A and RW. Go to ADDR.
  - req=1 and req_be=00: no bus activity. Go to END with err=0; rdata is unchanged.
- ADDR: A and RW stable, AS=1. Next state STRB. On the transition into STRB:
  - AS=0.
  - Read: UDS=~be[1], LDS=~be[0].
  - Write: D_OUT=wdata, D_OE=1.
- STRB: next state WAIT.
  - Write: the data strobes assert on entry to WAIT, one cycle after AS.
  - Read: strobes unchanged.
- WAIT:
  - berr_s=1: go to END with err=1. BERR takes priority over DTACK when both are high.
  - Else dtack_s=1: go to END with err=0. Read: rdata<=D_IN on this edge.
  - Else: remain in WAIT indefinitely (without BIU_TIMEOUT_EN).
- END, entered on the edge that leaves WAIT:
  - AS=UDS=LDS=1 and done=1 for exactly one cycle.
  - D_OE stays high one more cycle (write data hold).
  - Next state IDLE. On entry to IDLE: D_OE=0, done=0.
- req is ignored while busy=1. A req held high through done starts a new cycle from the IDLE edge. Back-to-back cycles therefore have AS high for at least 2 cycles (END + IDLE).
- Latency with DTACK already high:
  - E0 = IDLE edge accepting req.
  - AS falls at E1, done rises at E3, busy falls at E4.
  - Each extra cycle of DTACK delay adds one cycle.
- Single-byte read: only the enabled DS strobe falls. rdata takes the full D_IN, and the core selects the byte lane.

Optional Feature:
- Macro: BIU_TIMEOUT_EN.
- When defined:
  - An 8-bit (or wider) counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES with neither dtack_s nor berr_s high: go to END with err=1, identical to a BERR termination. rdata is unchanged.
  - A DTACK or BERR on the same cycle as the terminal count wins, with its normal meaning.
- When undefined: no counter exists, and WAIT waits forever.

Test Plan:
- Read, DTACK tied high, req_addr=0x000100, be=11, D_IN=0x4E71 -> AS low E1-E3, UDS/LDS low E1-E3, done at E3, rdata=0x4E71, err=0.
- Write, addr=0x000200, be=01, wdata=0xBEEF, DTACK raised 5 cycles after AS falls -> RW=0; D_OE from E1 through END; UDS stays high; LDS falls one cycle after AS; done 2 sync cycles after DTACK; err=0.
- BERR and DTACK asserted together during a read with D_IN=0x1234 -> done with err=1, rdata keeps its prior value.
- req_be=00 -> no AS pulse, done one cycle after acceptance, err=0.
- RESET pulled low asynchronously while in WAIT -> AS/UDS/LDS high and D_OE=0 before the next CLK edge; no done; the next req runs normally.
- BIU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and DTACK never asserted -> done with err=1 after 4 WAIT cycles. Without the macro: still busy after 1000 cycles.
